// File: rtl/n1_ir.sv
// n1_ir - instruction register stage of the N1 core.
// Holds the current opcode plus one stashed prefetch opcode. It loads
// forced opcodes for reset, exception, interrupt and bubble handling, and
// decodes the registered opcode into the control flags and operand fields
// used by the flow-control, stack and ALU stages.
// Optional build macro: N1_IR_PRB_EN adds probe ports for IR, stash and
// stash valid.
module n1_ir #(
    parameter logic [11:0] EXC_ADR = 12'h004,
    parameter logic [7:0]  ISR_VEC = 8'h00
) (
    input  logic        clk_i,
    input  logic        sync_rst_i,
    input  logic [15:0] pbus_dat_i,
    input  logic        fc2ir_capture_i,
    input  logic        fc2ir_stash_i,
    input  logic        fc2ir_expend_i,
    input  logic        fc2ir_force_eow_i,
    input  logic        fc2ir_force_0call_i,
    input  logic        fc2ir_force_call_i,
    input  logic        fc2ir_force_drop_i,
    input  logic        fc2ir_force_nop_i,
    input  logic        fc2ir_force_isr_i,
    output logic        ir2fc_eow_o,
    output logic        ir2fc_eow_postpone_o,
    output logic        ir2fc_jump_or_call_o,
    output logic        ir2fc_bra_o,
    output logic        ir2fc_isr_o,
    output logic        ir2fc_scyc_o,
    output logic        ir2fc_mem_o,
    output logic        ir2fc_mem_rd_o,
    output logic        ir2fc_madr_sel_o,
    output logic        ir2dsp_call_o,
    output logic [11:0] ir2dsp_adr_o,
    output logic        ir2prs_lit_val_o,
    output logic [15:0] ir2prs_lit_o,
`ifdef N1_IR_PRB_EN
    output logic [12:0] ir2alu_opr_o,
    output logic [15:0] prb_ir_o,
    output logic [15:0] prb_ir_stash_o,
    output logic        prb_ir_stash_vld_o
`else
    output logic [12:0] ir2alu_opr_o
`endif
);

    localparam logic [15:0] OP_NOP  = 16'h0000;
    localparam logic [15:0] OP_DROP = 16'h0001;
    localparam logic [15:0] OP_CALL = 16'h7000;
    localparam logic [15:0] OP_ISR  = 16'h1F00;

    logic [15:0] ir;
    logic [15:0] stash;
    logic        stash_vld;

    logic        force_any;
    logic        ir_load;
    logic [15:0] ir_src;
    logic [15:0] ir_nxt;

    assign force_any = fc2ir_force_0call_i | fc2ir_force_call_i | fc2ir_force_isr_i |
                       fc2ir_force_drop_i  | fc2ir_force_nop_i;
    assign ir_load   = force_any | fc2ir_expend_i | fc2ir_capture_i;

    // Select the IR source by priority; an empty stash expends as a NOP.
    always_comb begin
        ir_src = ir;
        if (fc2ir_force_0call_i)      ir_src = OP_CALL;
        else if (fc2ir_force_call_i)  ir_src = OP_CALL | {4'h0, EXC_ADR};
        else if (fc2ir_force_isr_i)   ir_src = OP_ISR | {8'h00, ISR_VEC};
        else if (fc2ir_force_drop_i)  ir_src = OP_DROP;
        else if (fc2ir_force_nop_i)   ir_src = OP_NOP;
        else if (fc2ir_expend_i)      ir_src = stash_vld ? stash : OP_NOP;
        else if (fc2ir_capture_i)     ir_src = pbus_dat_i;
        ir_nxt = ir_load ? ir_src : ir;
        ir_nxt[15] = ir_nxt[15] | fc2ir_force_eow_i;
    end

    // IR and stash registers; a fresh stash write always wins over a clear.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            ir        <= OP_CALL;
            stash     <= 16'h0000;
            stash_vld <= 1'b0;
        end else begin
            ir <= ir_nxt;
            if (fc2ir_stash_i) begin
                stash     <= pbus_dat_i;
                stash_vld <= 1'b1;
            end else if (force_any | fc2ir_expend_i) begin
                stash_vld <= 1'b0;
            end
        end
    end

    logic [1:0] op_cls;
    logic       is_jc, is_bra, is_mem, is_lit, is_isr;

    // Decode straight off the registered IR so flags track the load edge.
    always_comb begin
        op_cls = ir[14:13];
        is_jc  = (op_cls == 2'b11);
        is_bra = (op_cls == 2'b10);
        is_mem = (op_cls == 2'b01) &  ir[12];
        is_lit = (op_cls == 2'b01) & ~ir[12];
        is_isr = (op_cls == 2'b00) & (ir[12:8] == 5'h1F);
    end

    assign ir2fc_eow_o          = ir[15];
    assign ir2fc_eow_postpone_o = ir[15] & (is_jc | is_bra);
    assign ir2fc_jump_or_call_o = is_jc;
    assign ir2fc_bra_o          = is_bra;
    assign ir2fc_isr_o          = is_isr;
    assign ir2fc_scyc_o         = ~(is_jc | is_bra | is_mem | is_isr);
    assign ir2fc_mem_o          = is_mem;
    assign ir2fc_mem_rd_o       = is_mem & ir[11];
    assign ir2fc_madr_sel_o     = is_mem & ir[10];
    assign ir2dsp_call_o        = is_jc & ir[12];
    assign ir2dsp_adr_o         = ir[11:0];
    assign ir2prs_lit_val_o     = is_lit;
    assign ir2prs_lit_o         = {4'h0, ir[11:0]};
    assign ir2alu_opr_o         = ir[12:0];

`ifdef N1_IR_PRB_EN
    assign prb_ir_o           = ir;
    assign prb_ir_stash_o     = stash;
    assign prb_ir_stash_vld_o = stash_vld;
`endif

endmodule
